mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit that runs beside the ALU in the multi-cycle datapath.

---
 rtl/mult_div_unit.sv | 164 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add MULT/MULTU and restoring DIV/DIVU,
// one bit per clock, writing the HI/LO pair with a one-cycle done pulse.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             bz_q, bz_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  // Operand magnitudes; unsigned ops never see a sign flag.
  logic             sign_a_in, sign_b_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign sign_a_in = i_op[0] & i_a[WIDTH-1];
  assign sign_b_in = i_op[0] & i_b[WIDTH-1];
  assign a_mag     = sign_a_in ? WIDTH'(-i_a) : i_a;
  assign b_mag     = sign_b_in ? WIDTH'(-i_b) : i_b;

  // Per-iteration datapath; the divide trial includes the bit shifted out of rem.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [AW-1:0]    prod_neg;
  logic [WIDTH-1:0] quo, rem;
  assign mul_sum   = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, a_q};
  assign div_trial = acc_q[AW-1:WIDTH-1] - {1'b0, b_q};
  assign prod_neg  = AW'(-acc_q);
  assign quo       = acc_q[WIDTH-1:0];
  assign rem       = acc_q[AW-1:WIDTH];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          op_d    = i_op;
          a_d     = a_mag;
          b_d     = b_mag;
          sa_d    = sign_a_in;
          sb_d    = sign_b_in;
          bz_d    = (i_b == '0);
          acc_d   = {{WIDTH{1'b0}}, (i_op[1] ? a_mag : b_mag)};
          cnt_d   = '0;
          busy_d  = 1'b1;
          dz_d    = 1'b0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (op_q[1]) begin
          if (div_trial[WIDTH]) acc_d = {acc_q[AW-2:0], 1'b0};
          else                  acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          if (acc_q[0]) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          else          acc_d = {1'b0, acc_q[AW-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!op_q[1]) begin
          {hi_d, lo_d} = (sa_q ^ sb_q) ? prod_neg : acc_q;
        end else if (bz_q) begin
          hi_d = sa_q ? WIDTH'(-a_q) : a_q;
          lo_d = '1;
          dz_d = 1'b1;
        end else begin
          lo_d = (sa_q ^ sb_q) ? WIDTH'(-quo) : quo;
          hi_d = sa_q ? WIDTH'(-rem) : rem;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_hi       = hi_q;
  assign o_lo       = lo_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random operations,
// each checked against an arithmetic reference model.
module tb_mult_div_unit;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, dz;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_op       (op),
    .i_a        (a),
    .i_b        (b),
    .o_hi       (hi),
    .o_lo       (lo),
    .o_busy     (busy),
    .o_done     (done),
    .o_div_zero (dz)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Returns {div_zero, hi, lo} computed with plain arithmetic.
  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [2*W-1:0] p;
    longint         sp;
    int             sx, sy;
    case (o)
      2'd0: begin
        p = 64'(x) * 64'(y);
        return {1'b0, p};
      end
      2'd1: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        return {1'b0, 64'(sp)};
      end
      2'd2: begin
        if (y == '0) return {1'b1, x, {W{1'b1}}};
        return {1'b0, x % y, x / y};
      end
      default: begin
        if (y == '0) return {1'b1, x, {W{1'b1}}};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
        sx = $signed(x);
        sy = $signed(y);
        return {1'b0, 32'(sx % sy), 32'(sx / sy)};
      end
    endcase
  endfunction

  // mode 0: plain op; 1: stray start while busy; 2: async reset mid-calculation
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int mode);
    int           n;
    logic [2*W:0] r;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    chk("busy_after_start", W'(busy), W'(1));
    chk("div_zero_cleared", W'(dz), W'(0));
    n = 0;
    while (!done && n < 100) begin
      if (mode == 1 && n == 5) begin
        start = 1'b1; op = 2'd0; a = 1; b = 1;
      end else begin
        start = 1'b0;
      end
      if (mode == 2 && n == 10) begin
        #2 rst = 1'b1;
        #2;
        chk("reset_busy", W'(busy), W'(0));
        chk("reset_hi", hi, '0);
        chk("reset_lo", lo, '0);
        chk("reset_done", W'(done), W'(0));
        rst = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        @(posedge clk); #1;
        return;
      end
      if (n == 10) begin
        chk("hold_hi", hi, exp_hi);
        chk("hold_lo", lo, exp_lo);
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("latency", W'(n), W'(W + 1));
    r = model(o, x, y);
    exp_hi = r[2*W-1:W];
    exp_lo = r[W-1:0];
    chk("hi", hi, exp_hi);
    chk("lo", lo, exp_lo);
    chk("div_zero", W'(dz), W'(r[2*W]));
    chk("busy_at_done", W'(busy), W'(0));
    if (mode == 1) begin
      @(posedge clk); #1;
      chk("done_single_pulse", W'(done), W'(0));
      chk("hi_after_done", hi, exp_hi);
    end
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] rx, ry;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_div_zero", W'(dz), W'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'd1, 32'hFFFF_FFFD, 32'd5, 0);
    run_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'd2, 32'd100, 32'd7, 0);
    run_op(2'd2, 32'd7, 32'd0, 0);
    run_op(2'd0, 32'd12345, 32'd678, 0);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'd3, 32'hFFFF_FFFB, 32'd0, 0);
    run_op(2'd3, 32'd7, 32'hFFFF_FFFE, 0);
    run_op(2'd1, 32'h0000_1234, 32'hFFFF_ABCD, 1);
    run_op(2'd2, 32'd1000, 32'd3, 2);
    run_op(2'd3, 32'hFFFF_FF9C, 32'd7, 0);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       ry = '0;
        1:       ry = 32'hFFFF_FFFF;
        2:       ry = 32'd1;
        default: ry = 32'($urandom);
      endcase
      run_op(ro, rx, ry, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
